cpu_cycle_timer: RTL and testbench
==================================

Name: cpu_cycle_timer

Overview:
- Consumes the fast master clock (clkin) from the clock generator and derives 6502/ANTIC machine-cycle timing as clock-enable strobes.
- Generates the phi0 level, phi1/phi2 phase strobes and the CPU cycle enable.
- Applies ANTIC HALT and WSYNC CPU stalls.
- Tracks beam position (cycle within scanline, scanline within frame) for the downstream ANTIC/GTIA stages.

Parameters:
- DIV, 16: clkin ticks per machine cycle. Must be even and >= 4.
- CYC_PER_LINE, 114: machine cycles per scanline. Must be <= 128.
- LINES_PER_FRAME, 262: scanlines per frame. Must be <= 512.

Ports:
- clkin, input, 1: master clock.
- RST, input, 1: reset, synchronous, active-high.
- en, input, 1: run enable. Low freezes all state.
- halt_req, input, 1: ANTIC DMA halt request, level.
- wsync_req, input, 1: WSYNC write strobe, one clkin wide.
- phi0, output, 1: low during phi1 half, high during phi2 half.
- phi1_en, output, 1: one-tick strobe at phi1 start.
- phi2_en, output, 1: one-tick strobe at phi2 start.
- cyc_end, output, 1: one-tick strobe on the last tick of every machine cycle.
- cpu_ce, output, 1: one-tick CPU advance strobe, coincident with cyc_end, only when the CPU is not halted.
- halted, output, 1: current machine cycle is stalled.
- cycle_cnt, output, 7: machine cycle within the line.
- line_cnt, output, 9: scanline within the frame.
- line_start, output, 1: one-tick strobe at the first tick of cycle 0.
- frame_start, output, 1: line_start when line_cnt == 0.

Behaviour:
- Reset values: all outputs 0; tick counter t = 0; wsync_pend = 0. RST has priority over en. Reset mid-cycle aborts the cycle immediately.
- Tick counter t is ceil(log2(DIV)) bits, range 0..DIV-1. It increments on every clkin edge with en = 1 and wraps DIV-1 -> 0.
- All strobes and registered outputs are registered, and they are asserted during the tick in which t holds the named value:
  - t == 0: phi1_en = 1, phi0 = 0. If cycle_cnt == 0, line_start = 1; if line_cnt is also 0, frame_start = 1.
  - t == DIV/2: phi2_en = 1, phi0 goes to 1 and stays 1 through t == DIV-1.
  - t == DIV-1: cyc_end = 1; cpu_ce = ~halted.
- The first tick after RST deasserts (en = 1) is t = 0. phi1_en, line_start and frame_start are therefore all high in that tick.
- Beam counters update on the edge that ends the t == DIV-1 tick:
  - cycle_cnt wraps CYC_PER_LINE-1 -> 0.
  - On that wrap, line_cnt increments and wraps LINES_PER_FRAME-1 -> 0.
- wsync_pend:
  - Set by wsync_req = 1 on any enabled edge.
  - Cleared on the line-wrap edge (cycle_cnt == CYC_PER_LINE-1, t == DIV-1), unless wsync_req is also 1 on that same edge; set wins.
- halted is updated only on the cycle-end edge (t == DIV-1). The next cycle's halted = halt_req | wsync_pend_next, where wsync_pend_next is the value wsync_pend takes on that edge.
- halted is therefore constant for a whole machine cycle. A halt_req change mid-cycle affects only the following cycle.
- A WSYNC stall releases at cycle 0 of the next line: halted = 0 there unless halt_req is high.
- en = 0: t, counters, halted, wsync_pend and phi0 hold their values; all strobes are 0. wsync_req is ignored while en = 0.
- No combinational paths from inputs to outputs.

Test Plan:
- Cycle timing (DIV = 16): release RST with en = 1 → tick 0 has phi1_en, line_start and frame_start = 1; phi2_en at tick 8; phi0 high for ticks 8..15; cyc_end and cpu_ce at tick 15; pattern repeats every 16 ticks.
- Beam wrap: run 114 × 16 = 1824 ticks → second line_start at tick 1824 with line_cnt = 1. After 262 × 1824 = 477888 ticks → frame_start again with cycle_cnt = 0 and line_cnt = 0.
- Halt: raise halt_req at tick 5 of cycle 10, drop it at tick 5 of cycle 12 → cycle 10 cpu_ce = 1; cycles 11 and 12 halted = 1 with no cpu_ce; cycle 13 cpu_ce = 1.
- WSYNC: pulse wsync_req in cycle 50 → halted for cycles 51..113, no cpu_ce there; cycle 0 of the next line has cpu_ce = 1. Pulse on the line-wrap edge instead → the entire next line is halted, and the CPU resumes at cycle 0 of the line after.
- Freeze: deassert en for 37 ticks starting at t = 6 of cycle 20 → no strobes during the freeze; phi0 and counters unchanged; resumes at t = 7 of cycle 20.
- Reset mid-operation: assert RST at line 100, cycle 60, t = 9, with wsync_pend = 1 → next edge all outputs 0. After release: frame_start at the first tick, halted = 0, cpu_ce at tick 15.

Source files
------------

// File: rtl/cpu_cycle_timer.sv
// cpu_cycle_timer: divides clkin into 6502/ANTIC machine cycles and emits
// one-tick clock-enable strobes (phi1/phi2 starts, cycle end, CPU advance),
// applies ANTIC HALT / WSYNC stalls, and tracks the beam position.
// Every output is a flop; strobes are computed from the next tick value so
// they are high during the tick in which the tick counter holds that value.
module cpu_cycle_timer #(
  parameter int DIV             = 16,
  parameter int CYC_PER_LINE    = 114,
  parameter int LINES_PER_FRAME = 262
) (
  input  logic       clkin,
  input  logic       RST,
  input  logic       en,
  input  logic       halt_req,
  input  logic       wsync_req,
  output logic       phi0,
  output logic       phi1_en,
  output logic       phi2_en,
  output logic       cyc_end,
  output logic       cpu_ce,
  output logic       halted,
  output logic [6:0] cycle_cnt,
  output logic [8:0] line_cnt,
  output logic       line_start,
  output logic       frame_start
);

  localparam int TW = $clog2(DIV);
  localparam logic [TW-1:0] T_LAST = TW'(DIV - 1);
  localparam logic [TW-1:0] T_HALF = TW'(DIV / 2);
  localparam logic [6:0]    C_LAST = 7'(CYC_PER_LINE - 1);
  localparam logic [8:0]    L_LAST = 9'(LINES_PER_FRAME - 1);

  // run is low from reset until the first enabled edge; that edge enters
  // tick 0 rather than advancing, so the first running tick is t = 0.
  logic          run;
  logic [TW-1:0] t;
  logic          wsync_pend;

  logic          cyc_last;
  logic          line_last;
  logic [TW-1:0] t_next;
  logic [6:0]    cycle_next;
  logic [8:0]    line_next;
  logic          pend_next;
  logic          halted_next;

  // Next-state values for the edge that ends the current tick.
  always_comb begin
    cyc_last    = run && (t == T_LAST);
    line_last   = cyc_last && (cycle_cnt == C_LAST);
    t_next      = '0;
    if (run && (t != T_LAST)) begin
      t_next = t + TW'(1);
    end
    cycle_next  = cycle_cnt;
    if (cyc_last) begin
      cycle_next = (cycle_cnt == C_LAST) ? 7'd0 : cycle_cnt + 7'd1;
    end
    line_next   = line_cnt;
    if (line_last) begin
      line_next = (line_cnt == L_LAST) ? 9'd0 : line_cnt + 9'd1;
    end
    // A WSYNC write on the line-wrap edge re-arms the stall for the next line.
    pend_next   = wsync_req | (wsync_pend & ~line_last);
    halted_next = cyc_last ? (halt_req | pend_next) : halted;
  end

  // State and registered outputs; en low freezes state and silences strobes.
  always_ff @(posedge clkin) begin
    if (RST) begin
      run         <= 1'b0;
      t           <= '0;
      wsync_pend  <= 1'b0;
      halted      <= 1'b0;
      cycle_cnt   <= '0;
      line_cnt    <= '0;
      phi0        <= 1'b0;
      phi1_en     <= 1'b0;
      phi2_en     <= 1'b0;
      cyc_end     <= 1'b0;
      cpu_ce      <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else if (en) begin
      run         <= 1'b1;
      t           <= t_next;
      wsync_pend  <= pend_next;
      halted      <= halted_next;
      cycle_cnt   <= cycle_next;
      line_cnt    <= line_next;
      phi0        <= (t_next >= T_HALF);
      phi1_en     <= (t_next == '0);
      phi2_en     <= (t_next == T_HALF);
      cyc_end     <= (t_next == T_LAST);
      // halted cannot change on an edge entering the last tick, so the
      // current value is the one that applies to this cycle.
      cpu_ce      <= (t_next == T_LAST) & ~halted;
      line_start  <= (t_next == '0) && (cycle_next == 7'd0);
      frame_start <= (t_next == '0) && (cycle_next == 7'd0) && (line_next == 9'd0);
    end else begin
      phi1_en     <= 1'b0;
      phi2_en     <= 1'b0;
      cyc_end     <= 1'b0;
      cpu_ce      <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end
  end

endmodule

// File: tb/tb_cpu_cycle_timer.sv
// Testbench for cpu_cycle_timer: a reference model based on the absolute
// number of running ticks pushes the expected output vector for every edge;
// a separate monitor pops and compares after each edge.
module tb_cpu_cycle_timer;

  localparam int DIV = 16;
  localparam int CPL = 114;
  localparam int LPF = 4;

  logic       clkin = 1'b0;
  logic       RST = 1'b1;
  logic       en = 1'b0;
  logic       halt_req = 1'b0;
  logic       wsync_req = 1'b0;
  logic       phi0, phi1_en, phi2_en, cyc_end, cpu_ce, halted;
  logic [6:0] cycle_cnt;
  logic [8:0] line_cnt;
  logic       line_start, frame_start;

  cpu_cycle_timer #(.DIV(DIV), .CYC_PER_LINE(CPL), .LINES_PER_FRAME(LPF)) dut (
    .clkin(clkin), .RST(RST), .en(en), .halt_req(halt_req), .wsync_req(wsync_req),
    .phi0(phi0), .phi1_en(phi1_en), .phi2_en(phi2_en), .cyc_end(cyc_end),
    .cpu_ce(cpu_ce), .halted(halted), .cycle_cnt(cycle_cnt), .line_cnt(line_cnt),
    .line_start(line_start), .frame_start(frame_start)
  );

  always #5 clkin = ~clkin;

  logic [23:0] exp_q[$];
  int total = 0;
  int bad = 0;

  // model state: m_n = running ticks since release, m_started = released
  bit m_started = 0;
  int m_n = 0;
  bit m_halted = 0;
  bit m_pend = 0;
  bit cur_halt = 0;

  function automatic void model_edge(bit r, bit e, bit h, bit w);
    int tt, cc, ll;
    bit s;
    bit cend, lend;
    logic [23:0] v;
    if (r) begin
      m_started = 0; m_n = 0; m_halted = 0; m_pend = 0;
    end else if (e) begin
      cend = m_started && (m_n % DIV == DIV - 1);
      lend = cend && ((m_n / DIV) % CPL == CPL - 1);
      m_pend = w || (m_pend && !lend);
      if (cend) m_halted = h || m_pend;
      if (m_started) m_n++;
      else m_started = 1;
    end
    tt = m_n % DIV;
    cc = (m_n / DIV) % CPL;
    ll = (m_n / (DIV * CPL)) % LPF;
    s  = !r && e;
    v[23]   = m_started && (tt >= DIV / 2);
    v[22]   = s && tt == 0;
    v[21]   = s && tt == DIV / 2;
    v[20]   = s && tt == DIV - 1;
    v[19]   = s && tt == DIV - 1 && !m_halted;
    v[18]   = m_halted;
    v[17:11] = 7'(cc);
    v[10:2]  = 9'(ll);
    v[1]    = s && tt == 0 && cc == 0;
    v[0]    = s && tt == 0 && cc == 0 && ll == 0;
    exp_q.push_back(v);
  endfunction

  task automatic tick(bit r, bit e, bit h, bit w);
    @(negedge clkin);
    RST = r; en = e; halt_req = h; wsync_req = w;
    model_edge(r, e, h, w);
  endtask

  // advance with en high until the model sits in tick (tt, cycle cc, line ll)
  task automatic run_to(int tt, int cc, int ll);
    int guard;
    guard = 0;
    while (!(m_started && m_n % DIV == tt && (m_n / DIV) % CPL == cc &&
             (ll < 0 || (m_n / (DIV * CPL)) % LPF == ll))) begin
      tick(0, 1, cur_halt, 0);
      guard++;
      if (guard > 20000) begin
        total++; bad++;
        $display("FAIL run_to timeout: got no position after %0d ticks, want t=%0d cyc=%0d line=%0d",
                 guard, tt, cc, ll);
        return;
      end
    end
  endtask

  logic [23:0] mon_exp, mon_act;

  // monitor: compare every presented output vector against the scoreboard
  initial begin
    forever begin
      @(posedge clkin);
      #2;
      if (exp_q.size() > 0) begin
        mon_exp = exp_q.pop_front();
        mon_act = {phi0, phi1_en, phi2_en, cyc_end, cpu_ce, halted,
                   cycle_cnt, line_cnt, line_start, frame_start};
        total++;
        if (mon_act !== mon_exp) begin
          bad++;
          $display("FAIL outputs @%0t: got %h want %h", $time, mon_act, mon_exp);
        end
      end
    end
  end

  initial begin
    repeat (3) tick(1, 1, 0, 0);
    // halt window: raise in cycle 10, drop in cycle 12
    run_to(5, 10, 0); cur_halt = 1; tick(0, 1, 1, 0);
    run_to(5, 12, 0); cur_halt = 0; tick(0, 1, 0, 0);
    // WSYNC mid-line, then exactly on the line-wrap edge
    run_to(3, 50, 0); tick(0, 1, 0, 1);
    run_to(15, 113, 1); tick(0, 1, 0, 1);
    // freeze for 37 ticks; a WSYNC strobe while frozen must be ignored
    run_to(6, 20, 3);
    repeat (10) tick(0, 0, 0, 0);
    tick(0, 0, 0, 1);
    repeat (26) tick(0, 0, 0, 0);
    // frame wrap
    run_to(0, 0, 0);
    repeat (20) tick(0, 1, 0, 0);
    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(199) == 0) cur_halt = ~cur_halt;
      tick(0, ($urandom_range(15) != 0), cur_halt, ($urandom_range(299) == 0));
    end
    cur_halt = 0;
    // reset while a WSYNC stall is pending
    run_to(0, 30, 2); tick(0, 1, 0, 1);
    run_to(9, 60, 2); tick(1, 1, 0, 0);
    repeat (40) tick(0, 1, 0, 0);
    @(posedge clkin);
    #3;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard drain: got %0d left want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
